// File: rtl/c_bitwise_accum.sv
// Folds a valid/ready burst of WIDTH-bit words into one OR/AND/XOR/NOR result.
// Define C_BITWISE_ACCUM_BACK2BACK_EN to accept a new first word while the result drains.
module c_bitwise_accum #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LEN_W-1:0] out_count,
    output logic             out_trunc
);

    // state | meaning
    // IDLE  | waiting for the first word of a burst
    // ACCUM | folding further words into acc
    // HOLD  | result presented until the consumer takes it
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]       OP_AND  = 2'b01;
    localparam logic [1:0]       OP_XOR  = 2'b10;
    localparam logic [1:0]       OP_NOR  = 2'b11;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN);
    localparam bit               SINGLE  = (MAX_LEN == 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             trunc_q, trunc_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [LEN_W-1:0] count_inc;
    logic [WIDTH-1:0] acc_fold;

    always_comb begin
        in_ready = 1'b1;
        if (state_q == S_HOLD) begin
`ifdef C_BITWISE_ACCUM_BACK2BACK_EN
            in_ready = out_ready;
`else
            in_ready = 1'b0;
`endif
        end
    end

    assign out_valid = (state_q == S_HOLD);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign count_inc = count_q + CNT_ONE;

    // NOR folds as OR; the inversion happens only on the way out.
    always_comb begin
        acc_fold = acc_q | in_data;
        case (op_q)
            OP_AND:  acc_fold = acc_q & in_data;
            OP_XOR:  acc_fold = acc_q ^ in_data;
            default: acc_fold = acc_q | in_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        op_d    = op_q;
        trunc_d = trunc_q;
        case (state_q)
            S_ACCUM: begin
                if (in_xfer) begin
                    acc_d   = acc_fold;
                    count_d = count_inc;
                    if (in_last) begin
                        state_d = S_HOLD;
                        trunc_d = 1'b0;
                    end else if (count_inc == CNT_MAX) begin
                        state_d = S_HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // First word of a burst: from IDLE, or from HOLD while the result drains.
        if (in_xfer && (state_q != S_ACCUM)) begin
            op_d    = op;
            acc_d   = in_data;
            count_d = CNT_ONE;
            trunc_d = SINGLE && !in_last;
            state_d = (in_last || SINGLE) ? S_HOLD : S_ACCUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= 2'b00;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        out_data  = '0;
        out_count = '0;
        out_trunc = 1'b0;
        if (out_valid) begin
            out_data  = (op_q == OP_NOR) ? ~acc_q : acc_q;
            out_count = count_q;
            out_trunc = trunc_q;
        end
    end

endmodule

// File: tb/tb_c_bitwise_accum.sv
// Directed bench for c_bitwise_accum (WIDTH=16, MAX_LEN=4); expected values are hand-computed.
module tb_c_bitwise_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_count;
    logic        out_trunc;

    int errors = 0;
    int checks = 0;

    c_bitwise_accum #(.WIDTH(16), .MAX_LEN(4), .LEN_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    // Presents one word for one edge; caller guarantees in_ready is high.
    task automatic push(input logic [15:0] d, input logic last, input logic [1:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        op       = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL reset_out_trunc: got %b want 0", out_trunc); end
    endtask

    task automatic test_or();
        out_ready = 1'b1;
        push(16'h0001, 1'b0, 2'b00);
        push(16'h0100, 1'b0, 2'b00);
        push(16'h8000, 1'b1, 2'b00);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL or_latency: out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 16'h8101) begin errors++; $display("FAIL or_data: got %h want 8101", out_data); end
        checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL or_count: got %0d want 3", out_count); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL or_trunc: got %b want 0", out_trunc); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL or_idle_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL or_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ops();
        logic [1:0]  op1 [4] = '{2'b01, 2'b11, 2'b10, 2'b01};
        logic [1:0]  op2 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [15:0] exp [4] = '{16'hF000, 16'h000F, 16'h0FF0, 16'hF000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(16'hF0F0, 1'b0, op1[i]);
            push(16'hFF00, 1'b1, op2[i]);
            checks++; if (out_data !== exp[i]) begin errors++; $display("FAIL op_data[%0d]: got %h want %h", i, out_data, exp[i]); end
            checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL op_count[%0d]: got %0d want 2", i, out_count); end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(16'h00FF, 1'b0, 2'b10);
        push(16'h0F00, 1'b1, 2'b10);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== 16'h0FFF) begin errors++; $display("FAIL bp_data[%0d]: got %h want 0fff", i, out_data); end
            checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL bp_count[%0d]: got %0d want 2", i, out_count); end
            checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL bp_trunc[%0d]: got %b want 0", i, out_trunc); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_trunc();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(16'h0001 << i, 1'b0, 2'b00);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL trunc1_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 16'h000F) begin errors++; $display("FAIL trunc1_data: got %h want 000f", out_data); end
        checks++; if (out_count !== 5'd4) begin errors++; $display("FAIL trunc1_count: got %0d want 4", out_count); end
        checks++; if (out_trunc !== 1'b1) begin errors++; $display("FAIL trunc1_flag: got %b want 1", out_trunc); end
        step();
        push(16'h0010, 1'b0, 2'b00);
        push(16'h0020, 1'b1, 2'b00);
        checks++; if (out_data !== 16'h0030) begin errors++; $display("FAIL trunc2_data: got %h want 0030", out_data); end
        checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL trunc2_count: got %0d want 2", out_count); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL trunc2_flag: got %b want 0", out_trunc); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        push(16'h000F, 1'b0, 2'b00);
        push(16'h00F0, 1'b0, 2'b00);
        #3 reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 5'd0)
            begin errors++; $display("FAIL arst_accum: ready=%b valid=%b data=%h count=%0d want 1 0 0000 0", in_ready, out_valid, out_data, out_count); end
        #2 reset = 1'b0;
        step();
        // Reset while a result is being held must drop it without waiting for a clock.
        out_ready = 1'b0;
        push(16'h4444, 1'b1, 2'b11);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_hold: out_valid got %b want 1", out_valid); end
        #3 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_count !== 5'd0 || out_trunc !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_hold: valid=%b data=%h count=%0d trunc=%b ready=%b want 0 0000 0 0 1", out_valid, out_data, out_count, out_trunc, in_ready); end
        #2 reset = 1'b0;
        out_ready = 1'b1;
        step();
        push(16'h1234, 1'b1, 2'b00);
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL arst_after_data: got %h want 1234", out_data); end
        checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL arst_after_count: got %0d want 1", out_count); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3] = '{16'hAAAA, 16'h5555, 16'h0F0F};
        logic [15:0] got_d [3];
        int          got_c [3];
        int          idx = 0;
        int          nres = 0;
        int          gap_exp;
        logic        acc;
`ifdef C_BITWISE_ACCUM_BACK2BACK_EN
        gap_exp = 1;
`else
        gap_exp = 2;
`endif
        out_ready = 1'b1;
        in_last   = 1'b1;
        op        = 2'b00;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? words[idx] : 16'h0000;
            acc      = in_valid && in_ready;
            step();
            if (acc) idx++;
            if (out_valid === 1'b1 && nres < 3) begin
                got_d[nres] = out_data;
                got_c[nres] = c;
                nres++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_count: got %0d results want 3", nres); end
        for (int i = 0; i < 3; i++) begin
            if (i < nres) begin
                checks++; if (got_d[i] !== words[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_d[i], words[i]); end
            end
            if (i > 0 && i < nres) begin
                checks++; if (got_c[i] - got_c[i-1] !== gap_exp) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, got_c[i] - got_c[i-1], gap_exp); end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        op        = 2'b00;
        out_ready = 1'b1;
        #12;
        test_reset();
        reset = 1'b0;
        step();
        test_or();
        test_ops();
        test_backpressure();
        test_trunc();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c_bitwise_accum.md
Name: c_bitwise_accum

Overview:
- Parametrised, sequential successor of the 16-bit bitwise OR chip.
- Folds a burst of WIDTH-bit words into one result, using a selectable bitwise operation: OR, AND, XOR or NOR.
- Valid/ready stream in, valid/ready result out.
- Used by ALU-side test/diagnostic logic that needs bitwise reductions over multi-word operands.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- MAX_LEN, 16, maximum words per burst; the burst is force-terminated at this count.
- LEN_W, 5, width of the word counter; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept an input word.
- in_data  input  WIDTH  input word.
- in_last  input  1  marks the final word of a burst.
- op  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR. Sampled only on the first word of a burst.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  reduced result.
- out_count  output  LEN_W  number of words folded into out_data.
- out_trunc  output  1  burst was force-terminated at MAX_LEN without in_last.

Behaviour:
- Transfers: an input transfer is in_valid & in_ready at a rising clk. An output transfer is out_valid & out_ready.
- Reset, asynchronous and immediate, also mid-burst:
  - state=IDLE, acc=0, count=0, op_r=00, trunc=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0, out_trunc=0.
  - Any partial burst is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0 (see Optional Feature), out_valid=1.
- IDLE, on transfer:
  - op_r<=op, acc<=in_data, count<=1.
  - If in_last or MAX_LEN==1: go to HOLD. Else go to ACCUM.
- ACCUM, on transfer:
  - acc<=acc OP_r in_data, count<=count+1.
  - OR/AND/XOR are plain bitwise operations.
  - NOR: accumulate as OR internally; invert only at the output.
  - If in_last: go to HOLD, trunc<=0.
  - Else if count+1==MAX_LEN: go to HOLD, trunc<=1. The following words start a new burst.
- HOLD:
  - out_data = acc, or ~acc when op_r==11. out_count=count, out_trunc=trunc.
  - All three are stable while out_valid=1 and out_ready=0.
  - On output transfer: go to IDLE. acc/count keep their values but are not observable (out_valid=0).
- Latency: out_valid asserts on the cycle after the last word's transfer.
- Throughput without the feature: one bubble cycle per burst (HOLD->IDLE).
- Changes to op mid-burst are ignored; op_r governs the whole burst.
- in_last on a word is ignored when in_valid=0.
- Idle input (in_valid=0) in ACCUM holds state indefinitely; there is no timeout.
- out_data/out_count/out_trunc are registered or derived combinationally from registered state only. No combinational path from in_* to out_*.
- in_ready depends only on state (plus out_ready under the feature).

Optional Feature:
- Macro: C_BITWISE_ACCUM_BACK2BACK_EN.
- Defined:
  - In HOLD, in_ready = out_ready.
  - An input transfer in the same cycle as the output transfer is treated as an IDLE first-word transfer: load op_r/acc/count, then go to ACCUM, or straight to HOLD if in_last.
  - Zero-bubble throughput; a stream of 1-word bursts yields one result per cycle.
- Undefined: in_ready=0 in HOLD; behaviour exactly as above.

Test Plan:
- OR burst, WIDTH=16: op=00; words 0x0001, 0x0100, 0x8000 (last on 3rd); out_ready=1 -> out_valid the cycle after the 3rd transfer; out_data=0x8101, out_count=3, out_trunc=0; IDLE next cycle.
- AND/NOR/XOR, one burst each, words 0xF0F0 then 0xFF00:
  - op=01 -> 0xF000.
  - op=11 -> ~0xFFF0 = 0x000F.
  - op=10 -> 0x0FF0.
  - op toggled to 00 on the 2nd word -> result unchanged.
- Backpressure: complete a burst with out_ready=0 for 5 cycles -> out_valid=1, data/count/trunc stable, in_ready=0 (feature off); out_ready=1 -> one transfer, then IDLE.
- Truncation, MAX_LEN=4: 6 words of 0x0001<<i, in_last never set, op=00:
  - First result: out_data=0x000F, out_count=4, out_trunc=1.
  - Then word 5 plus word 6 with in_last: out_data=0x0030, out_count=2, out_trunc=0.
- Async reset: assert reset mid-ACCUM after 2 words, asynchronously between clk edges -> outputs go to reset values immediately. After release, a 1-word burst 0x1234 gives out_data=0x1234, out_count=1.
- Back-to-back, feature on: 1-word bursts 0xAAAA, 0x5555, 0x0F0F with in_valid and out_ready held at 1 -> results on 3 consecutive cycles. Feature off: same stimulus gives one idle cycle between results.
